// File: rtl/vga_pattern_gen.sv
// VGA timing generator with a run-time selectable RGB565 test pattern.
// Every output is registered from the current counter state, so all outputs share one cycle of latency.
module vga_pattern_gen #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_VALID   = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_VALID   = 480,
  parameter int V_FRONT   = 10,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int CNT_W     = 10,
  parameter int CHK_SHIFT = 5
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic [1:0]       mode,
  input  logic [15:0]      fg_color,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [15:0]      rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_ACT_S = H_SYNC + H_BACK;
  localparam int V_ACT_S = V_SYNC + V_BACK;
  localparam int BAR_W   = H_VALID / 8;

  // Region bounds are one bit wider than the counters so a total of exactly 2^CNT_W still fits.
  localparam logic [CNT_W:0]   H_SYNC_E  = (CNT_W+1)'(H_SYNC);
  localparam logic [CNT_W:0]   V_SYNC_E  = (CNT_W+1)'(V_SYNC);
  localparam logic [CNT_W:0]   H_ACT_S_E = (CNT_W+1)'(H_ACT_S);
  localparam logic [CNT_W:0]   H_ACT_E_E = (CNT_W+1)'(H_ACT_S + H_VALID);
  localparam logic [CNT_W:0]   V_ACT_S_E = (CNT_W+1)'(V_ACT_S);
  localparam logic [CNT_W:0]   V_ACT_E_E = (CNT_W+1)'(V_ACT_S + V_VALID);
  localparam logic [CNT_W-1:0] H_ACT_S_N = CNT_W'(H_ACT_S);
  localparam logic [CNT_W-1:0] V_ACT_S_N = CNT_W'(V_ACT_S);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic             H_ACT_LVL = (H_POL != 0);
  localparam logic             V_ACT_LVL = (V_POL != 0);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;
  logic             act;
  logic             at_origin;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_d;
  logic [2:0]       bar_idx;
  logic [15:0]      rgb_d;
  logic [1:0]       mode_r;
  logic [15:0]      color_r;

  assign h_ext     = {1'b0, h_cnt};
  assign v_ext     = {1'b0, v_cnt};
  assign act       = (h_ext >= H_ACT_S_E) && (h_ext < H_ACT_E_E) &&
                     (v_ext >= V_ACT_S_E) && (v_ext < V_ACT_E_E);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Pattern controls only change at the frame origin so a frame is never drawn half-and-half.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_r  <= 2'd0;
      color_r <= 16'h0000;
    end else if (at_origin) begin
      mode_r  <= mode;
      color_r <= fg_color;
    end
  end

  always_comb begin
    x_d = '0;
    y_d = '0;
    if (act) begin
      x_d = h_cnt - H_ACT_S_N;
      y_d = v_cnt - V_ACT_S_N;
    end
  end

  // Counting passed bar boundaries avoids a divider and saturates at 7 for the leftover pixels.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, x_d} >= (CNT_W+1)'(BAR_W * k)) bar_idx = 3'(k);
    end
  end

  always_comb begin
    rgb_d = 16'h0000;
    if (act) begin
      case (mode_r)
        2'd0: begin
          case (bar_idx)
            3'd0:    rgb_d = 16'hF800;
            3'd1:    rgb_d = 16'hFC00;
            3'd2:    rgb_d = 16'hFFE0;
            3'd3:    rgb_d = 16'h07E0;
            3'd4:    rgb_d = 16'h07FF;
            3'd5:    rgb_d = 16'h001F;
            3'd6:    rgb_d = 16'hF81F;
            default: rgb_d = 16'hFFFF;
          endcase
        end
        2'd1:    rgb_d = (x_d[CHK_SHIFT] ^ y_d[CHK_SHIFT]) ? 16'hFFFF : 16'h0000;
        2'd2:    rgb_d = color_r;
        default: rgb_d = {x_d[9:5], y_d[8:3], 5'h1F - x_d[9:5]};
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= ~H_ACT_LVL;
      vsync       <= ~V_ACT_LVL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      rgb         <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_ext < H_SYNC_E) ? H_ACT_LVL : ~H_ACT_LVL;
      vsync       <= (v_ext < V_SYNC_E) ? V_ACT_LVL : ~V_ACT_LVL;
      de          <= act;
      pix_x       <= x_d;
      pix_y       <= y_d;
      rgb         <= rgb_d;
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken timing set: a cycle-count reference model feeds an
// expected queue, a table of hand-derived pixel values is spot-checked, plus reset/mode-switch sequences.
module tb_vga_pattern_gen;

  localparam int HS = 4, HB = 4, HV = 84, HF = 4;
  localparam int VS = 2, VB = 2, VV = 40, VF = 2;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;
  localparam int CW = 10;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic [15:0]   fg_color;
  logic          hsync, vsync, de, frame_start;
  logic [CW-1:0] pix_x, pix_y;
  logic [15:0]   rgb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] exp_q[$];
  int          tcount;
  logic [1:0]  m_mode;
  logic [15:0] m_color;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] fg;
    int          x;
    int          y;
    logic [15:0] rgb;
  } spot_t;
  spot_t tbl[15];

  vga_pattern_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .H_POL(0), .V_POL(0), .CNT_W(CW), .CHK_SHIFT(3)
  ) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .mode(mode), .fg_color(fg_color),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .rgb(rgb), .frame_start(frame_start)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] bar_color(int i);
    case (i)
      0: return 16'hF800;
      1: return 16'hFC00;
      2: return 16'hFFE0;
      3: return 16'h07E0;
      4: return 16'h07FF;
      5: return 16'h001F;
      6: return 16'hF81F;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Expected {frame_start, hsync, vsync, de, pix_x, pix_y, rgb} for the t-th cycle after release.
  function automatic logic [39:0] model(int t, logic [1:0] md, logic [15:0] col);
    int h, v, px, py, idx, r, g;
    logic act;
    logic [15:0] c;
    h   = t % HT;
    v   = (t / HT) % VT;
    act = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    px  = act ? h - (HS + HB) : 0;
    py  = act ? v - (VS + VB) : 0;
    c   = 16'h0000;
    if (act) begin
      case (md)
        2'd0: begin
          idx = px / (HV / 8);
          if (idx > 7) idx = 7;
          c = bar_color(idx);
        end
        2'd1: c = ((((px >> 3) ^ (py >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        2'd2: c = col;
        default: begin
          r = (px >> 5) & 31;
          g = (py >> 3) & 63;
          c = {5'(r), 6'(g), 5'(31 - r)};
        end
      endcase
    end
    return {(h == 0 && v == 0), (h >= HS), (v >= VS), act, CW'(px), CW'(py), c};
  endfunction

  // scoreboard: push the model's expectation at the edge, pop and compare just after it
  initial begin : scoreboard
    logic [39:0] e, got;
    int h, v;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        tcount  = 0;
        m_mode  = 2'd0;
        m_color = 16'h0000;
      end else begin
        h = tcount % HT;
        v = (tcount / HT) % VT;
        if (h == 0 && v == 0) begin
          m_mode  = mode;
          m_color = fg_color;
        end
        exp_q.push_back(model(tcount, m_mode, m_color));
        tcount++;
        #1;
        if (exp_q.size() > 0) begin
          e   = exp_q.pop_front();
          got = {frame_start, hsync, vsync, de, pix_x, pix_y, rgb};
          n_cmp++;
          if (got !== e) begin
            n_bad++;
            $display("FAIL sb t=%0d: got fs=%b hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h, expected fs=%b hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h",
                     tcount - 1, got[39], got[38], got[37], got[36], got[35:26], got[25:16], got[15:0],
                     e[39], e[38], e[37], e[36], e[35:26], e[25:16], e[15:0]);
          end
        end
      end
    end
  end

  // driver / check tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FT && !ok; i++) begin
      @(negedge clk);
      if (frame_start) ok = 1'b1;
    end
    if (!ok) check("timeout_frame_start", 32'd0, 32'd1);
  endtask

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FT && !ok; i++) begin
      @(negedge clk);
      if (de && pix_x == CW'(x) && pix_y == CW'(y)) ok = 1'b1;
    end
    if (!ok) check("timeout_pixel", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_de"}, 32'(de), 32'd0);
    check({tag, "_rgb"}, 32'(rgb), 32'd0);
    check({tag, "_pix"}, {pix_x, pix_y}, 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin : main
    bit ok;
    int de_n, hs_n, vs_n, fs_n;

    // bar width 10 with 84 active pixels: x>=70 saturates to bar 7; checker squares are 8 pixels
    tbl[0]  = '{2'd0, 16'h0000, 0,  0,  16'hF800};
    tbl[1]  = '{2'd0, 16'h0000, 69, 0,  16'hF81F};
    tbl[2]  = '{2'd0, 16'h0000, 70, 0,  16'hFFFF};
    tbl[3]  = '{2'd0, 16'h0000, 60, 1,  16'hF81F};
    tbl[4]  = '{2'd0, 16'h0000, 10, 5,  16'hFC00};
    tbl[5]  = '{2'd0, 16'h0000, 83, 39, 16'hFFFF};
    tbl[6]  = '{2'd1, 16'h0000, 0,  0,  16'h0000};
    tbl[7]  = '{2'd1, 16'h0000, 8,  0,  16'hFFFF};
    tbl[8]  = '{2'd1, 16'h0000, 0,  8,  16'hFFFF};
    tbl[9]  = '{2'd1, 16'h0000, 8,  8,  16'h0000};
    tbl[10] = '{2'd2, 16'h1234, 5,  5,  16'h1234};
    tbl[11] = '{2'd2, 16'h1234, 83, 39, 16'h1234};
    tbl[12] = '{2'd3, 16'h0000, 0,  0,  16'h001F};
    tbl[13] = '{2'd3, 16'h0000, 64, 8,  16'h103D};
    tbl[14] = '{2'd3, 16'h0000, 83, 39, 16'h109D};

    rst_n    = 1'b0;
    mode     = 2'd0;
    fg_color = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // first edge after release shows the origin
    @(posedge clk);
    #2;
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_hsync", 32'(hsync), 32'd0);
    check("first_vsync", 32'(vsync), 32'd0);

    // one full frame of region counts, then the next frame_start lands exactly one frame later
    wait_fs(ok);
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int i = 0; i < FT; i++) begin
      if (i > 0) @(negedge clk);
      de_n += int'(de);
      hs_n += int'(!hsync);
      vs_n += int'(!vsync);
      fs_n += int'(frame_start);
    end
    check("de_per_frame", 32'(de_n), 32'(HV * VV));
    check("hsync_per_frame", 32'(hs_n), 32'(HS * VT));
    check("vsync_per_frame", 32'(vs_n), 32'(VS * HT));
    check("fs_per_frame", 32'(fs_n), 32'd1);
    @(negedge clk);
    check("fs_period", 32'(frame_start), 32'd1);

    for (int i = 0; i < 15; i++) begin
      if (i == 0 || tbl[i].mode != tbl[i-1].mode || tbl[i].fg != tbl[i-1].fg) begin
        mode     = tbl[i].mode;
        fg_color = tbl[i].fg;
        wait_fs(ok);
      end
      wait_pix(tbl[i].x, tbl[i].y, ok);
      if (ok) check($sformatf("spot_m%0d_%0d_%0d", tbl[i].mode, tbl[i].x, tbl[i].y), 32'(rgb), 32'(tbl[i].rgb));
    end

    // mid-frame switch 0 -> 3 only takes effect at the next frame
    mode = 2'd0;
    wait_fs(ok);
    wait_pix(0, 20, ok);
    mode = 2'd3;
    wait_pix(83, 39, ok);
    if (ok) check("switch_same_frame", 32'(rgb), 32'h0000FFFF);
    wait_pix(83, 39, ok);
    if (ok) check("switch_next_frame", 32'(rgb), 32'h0000109D);

    // reset mid-line clears outputs without a clock edge
    wait_pix(20, 10, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_hsync", 32'(hsync), 32'd0);
    check("restart_vsync", 32'(vsync), 32'd0);
    repeat (3 * HT) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing generator and test-pattern source, clocked by the pixel clock. It produces sync, data-enable and pixel coordinates for any standard timing set by parameters, and drives RGB565 pixel data. The pattern comes from a run-time mode select: colour bars, checkerboard, solid colour or gradient. It sits directly in front of the VGA DAC/pins and replaces the fixed 640x480 display block.

Parameters:
H_SYNC, 96, horizontal sync pulse width in pixel clocks
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch
V_VALID, 480, active lines per frame
V_FRONT, 10, vertical front porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CNT_W, 10, counter/coordinate width; H_TOTAL and V_TOTAL must both be <= 2^CNT_W; CNT_W >= 10
CHK_SHIFT, 5, checkerboard square size = 2^CHK_SHIFT pixels

Ports:
vga_clk  in  1  pixel clock (25 MHz for defaults)
sys_rst_n  in  1  asynchronous active-low reset
mode  in  2  pattern select: 0 bars, 1 checker, 2 solid, 3 gradient
fg_color  in  16  RGB565 colour for solid mode
hsync  out  1  line sync, polarity per H_POL
vsync  out  1  field sync, polarity per V_POL
de  out  1  high during active pixels
pix_x  out  CNT_W  active-area x coordinate, 0 outside active area
pix_y  out  CNT_W  active-area y coordinate, 0 outside active area
rgb  out  16  RGB565 pixel data
frame_start  out  1  one-cycle pulse aligned with h=0, v=0

Behaviour:
- Reset is asynchronous and active-low on sys_rst_n, single clock vga_clk.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800); V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 and wraps to 0.
- Region order per line and per frame: sync, back porch, active, front porch.
- Sync is asserted while h_cnt < H_SYNC (hsync) and while v_cnt < V_SYNC (vsync).
- Active when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
- Inside the active area, pix_x = h_cnt-(H_SYNC+H_BACK) and pix_y = v_cnt-(V_SYNC+V_BACK).
- All outputs are registered. Outputs at cycle n+1 reflect counter state at cycle n, so all outputs are mutually aligned with 1-cycle latency.
- Mode latching:
  - mode and fg_color are sampled into mode_r/color_r only when h_cnt==0 and v_cnt==0. Mid-frame changes take effect at the next frame.
  - mode_r resets to 0 and color_r resets to 0.
- Patterns (active area only):
  - mode 0: 8 vertical bars, each H_VALID/8 wide, in order RED F800, ORANGE FC00, YELLOW FFE0, GREEN 07E0, CYAN 07FF, BLUE 001F, PURPLE F81F, WHITE FFFF. Bar index saturates at 7 when H_VALID is not a multiple of 8.
  - mode 1: WHITE FFFF if pix_x[CHK_SHIFT]^pix_y[CHK_SHIFT], else BLACK 0000.
  - mode 2: color_r.
  - mode 3: R=pix_x[9:5], G=pix_y[8:3], B=5'h1F-pix_x[9:5].
- Outside the active area: rgb=0, de=0, pix_x=pix_y=0.
- frame_start is high for exactly one cycle per frame, the cycle when the outputs reflect h_cnt=0, v_cnt=0.
- Reset values: h_cnt=v_cnt=0; hsync=~H_POL and vsync=~V_POL (inactive); de=0, pix_x=pix_y=0, rgb=0, frame_start=0.
- First rising edge after release:
  - counters advance to h_cnt=1.
  - outputs reflect counter state h=0, v=0: frame_start=1, hsync/vsync active.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock. The frame restarts from h=0, v=0 after release.

Test Plan:
1. Defaults, mode=0, run 2 frames -> hsync low for 96 of every 800 cycles; vsync low for 1600 cycles every 420000; frame_start pulses exactly 420000 cycles apart.
2. Active window -> first de=1 at line 35, h 144; 640 de cycles per line; 480 active lines per frame; pix_x runs 0..639, pix_y 0..479.
3. Mode 0 -> rgb=F800 at pix_x=0, FC00 at pix_x=80, F81F at pix_x=480, FFFF at pix_x=639; rgb=0 whenever de=0.
4. Mode 1 -> (0,0)=0000, (32,0)=FFFF, (32,32)=0000; mode 2 with fg_color=1234 -> every active pixel is 1234.
5. Switch mode 0->3 at line 200 -> rest of the frame stays bars; next frame is gradient, with pixel (639,479) = {5'd19, 6'd59, 5'd12} = 9F6C.
6. Assert sys_rst_n low for 3 cycles mid-line -> outputs immediately reset (hsync=vsync=1, de=0, rgb=0); after release, frame_start on the first edge and timing restarts from h=0, v=0.
